// File: rtl/mac_fcs_tx_ctrl_pkg.sv
// Shared types and constants for the MAC transmit FCS sequencer.
package mac_fcs_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DATA,
    PAD,
    WAIT_CRC,
    FCS
  } fcs_state_e;

  localparam int          FCS_BYTES = 4;
  localparam logic [31:0] CRC_SEED  = 32'hFFFF_FFFF;

  // Byte counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mac_fcs_tx_ctrl_if.sv
// Byte-wide valid/ready stream with an end-of-frame marker; used for both framer and PHY sides.
interface mac_fcs_tx_ctrl_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (output valid, output data, output last, input  ready);
  modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/mac_fcs_tx_ctrl.sv
// Sequences a byte-wide CRC32 engine: forwards frame bytes, waits for the CRC, appends 4 FCS bytes.
// Optional runt padding to MIN_LEN bytes is enabled by defining MAC_FCS_PAD_EN.
module mac_fcs_tx_ctrl
  import mac_fcs_tx_ctrl_pkg::*;
#(
  parameter int CRC_WAIT_MAX = 8,
  parameter int MIN_LEN      = 60,
  parameter bit FCS_INVERT   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  mac_fcs_tx_ctrl_if.slave    s,
  mac_fcs_tx_ctrl_if.master   m,
  output logic                crc_init,
  output logic                crc_vld_o,
  output logic [7:0]          crc_data_o,
  output logic                crc_last_o,
  input  logic [31:0]         crc_out,
  input  logic                crc_valid,
  output logic                busy,
  output logic                crc_timeout,
  output logic [15:0]         frame_cnt
);

`ifdef MAC_FCS_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int              WCW       = $clog2(CRC_WAIT_MAX) + 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(CRC_WAIT_MAX - 1);
  localparam logic [1:0]      IDX_LAST  = 2'(FCS_BYTES - 1);

  fcs_state_e     state_q,     state_d;
  logic [15:0]    byte_cnt_q,  byte_cnt_d;
  logic [31:0]    fcs_q,       fcs_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]     idx_q,       idx_d;
  logic [WCW-1:0] wait_cnt_q,  wait_cnt_d;

  logic [15:0]    cnt_inc;
  logic [31:0]    crc_fcs;
  logic           fcs_last;

  assign cnt_inc   = sat_inc16(byte_cnt_q);
  assign crc_fcs   = FCS_INVERT ? ~crc_out : crc_out;
  assign fcs_last  = (idx_q == IDX_LAST);
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      fcs_q       <= '0;
      frame_cnt_q <= '0;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      fcs_q       <= fcs_d;
      frame_cnt_q <= frame_cnt_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    fcs_d       = fcs_q;
    frame_cnt_d = frame_cnt_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    s.ready     = 1'b0;
    m.valid     = 1'b0;
    m.data      = 8'h00;
    m.last      = 1'b0;
    crc_init    = 1'b0;
    crc_vld_o   = 1'b0;
    crc_data_o  = 8'h00;
    crc_last_o  = 1'b0;
    crc_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        if (s.valid) state_d = INIT;
      end

      INIT: begin
        crc_init   = 1'b1;
        idx_d      = '0;
        wait_cnt_d = '0;
        state_d    = DATA;
      end

      DATA: begin
        s.ready = m.ready;
        m.valid = s.valid;
        m.data  = s.data;
        if (s.valid && m.ready) begin
          crc_vld_o  = 1'b1;
          crc_data_o = s.data;
          byte_cnt_d = cnt_inc;
          if (s.last) begin
            // Runt check uses the count including the byte being transferred now.
            if (PAD_EN && (cnt_inc < 16'(MIN_LEN))) begin
              state_d = PAD;
            end else begin
              crc_last_o = 1'b1;
              state_d    = WAIT_CRC;
            end
          end
        end
      end

`ifdef MAC_FCS_PAD_EN
      PAD: begin
        m.valid = 1'b1;
        if (m.ready) begin
          crc_vld_o  = 1'b1;
          byte_cnt_d = cnt_inc;
          if (cnt_inc >= 16'(MIN_LEN)) begin
            crc_last_o = 1'b1;
            state_d    = WAIT_CRC;
          end
        end
      end
`endif

      WAIT_CRC: begin
        if (crc_valid) begin
          fcs_d   = crc_fcs;
          state_d = FCS;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Engine never answered: still close the frame with whatever it presents.
          crc_timeout = 1'b1;
          fcs_d       = crc_fcs;
          state_d     = FCS;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      FCS: begin
        m.valid = 1'b1;
        m.data  = fcs_q[8*idx_q +: 8];
        m.last  = fcs_last;
        if (m.ready) begin
          idx_d = idx_q + 2'd1;
          if (fcs_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            byte_cnt_d  = '0;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
